// File: rtl/spi_status_responder_if.sv
// SPI pin bundle between the ARM (master) and the FPGA status responder (slave).
// The ARM drives spck/ncs; the responder drives miso and its output enable.
interface spi_status_responder_if;
  logic spck;
  logic ncs;
  logic miso;
  logic miso_oe;

  modport master (output spck, output ncs, input miso, input miso_oe);
  modport slave  (input spck, input ncs, output miso, output miso_oe);
endinterface

// File: rtl/spi_status_responder.sv
// SPI status readback transmitter. Oversamples the asynchronous SPI pins in the
// ck_1356meg domain, captures a status word when ncs falls and shifts it out
// MSB first on miso, changing data after each falling spck edge (mode 0).
module spi_status_responder #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 ck_1356meg,
  input  logic                 rst_n,
  spi_status_responder_if.slave spi,
  input  logic [WIDTH-1:0]     status,
  input  logic                 err_clr,
  output logic                 frame_done,
  output logic                 xfer_err
);

  localparam int               CNT_W    = $clog2(WIDTH + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WIDTH + 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                 state, state_next;
  logic [SYNC_STAGES-1:0] spck_sync, ncs_sync, fill;
  logic                   spck_prev, ncs_prev, armed;
  logic                   spck_s, ncs_s;
  logic                   spck_rise, spck_fall, ncs_rise, ncs_fall;
  logic [CNT_W-1:0]       count, count_next;
  logic [WIDTH-1:0]       shreg, shreg_next;
  logic                   tx_bit, tx_bit_next;
  logic                   tx_en, tx_en_next;
  logic                   done_next, err_set;

  assign spck_s    = spck_sync[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync[SYNC_STAGES-1];
  assign spck_rise = spck_s & ~spck_prev;
  assign spck_fall = ~spck_s & spck_prev;
  assign ncs_rise  = ncs_s & ~ncs_prev;
  assign ncs_fall  = ~ncs_s & ncs_prev;

  assign spi.miso    = tx_bit;
  assign spi.miso_oe = tx_en;

  // Pin synchronizers, edge-detect registers and the armed flag. The fill
  // chain marks when the synchronizer output holds real pin samples rather
  // than reset values, so armed only reflects a genuinely high ncs and a frame
  // already running at reset release cannot be mistaken for a new one.
  always_ff @(posedge ck_1356meg) begin
    if (!rst_n) begin
      spck_sync <= '0;
      ncs_sync  <= '1;
      fill      <= '0;
      spck_prev <= 1'b0;
      ncs_prev  <= 1'b1;
      armed     <= 1'b0;
    end else begin
      spck_sync <= {spck_sync[SYNC_STAGES-2:0], spi.spck};
      ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], spi.ncs};
      fill      <= {fill[SYNC_STAGES-2:0], 1'b1};
      spck_prev <= spck_s;
      ncs_prev  <= ncs_s;
      if (fill[SYNC_STAGES-1] && ncs_s) armed <= 1'b1;
    end
  end

  // Frame sequencing: next state, bit count, shift register and pin drive.
  // ncs rising takes priority so a coincident spck edge is never counted.
  always_comb begin
    state_next  = state;
    count_next  = count;
    shreg_next  = shreg;
    tx_bit_next = tx_bit;
    tx_en_next  = tx_en;
    done_next   = 1'b0;
    err_set     = 1'b0;
    case (state)
      IDLE: begin
        count_next  = '0;
        tx_bit_next = 1'b0;
        tx_en_next  = 1'b0;
        if (ncs_fall && armed) begin
          shreg_next  = status;
          tx_bit_next = status[WIDTH-1];
          tx_en_next  = 1'b1;
          state_next  = ACTIVE;
        end
      end
      ACTIVE: begin
        if (ncs_rise) begin
          state_next  = IDLE;
          count_next  = '0;
          tx_bit_next = 1'b0;
          tx_en_next  = 1'b0;
          if (count == CNT_FULL) done_next = 1'b1;
          else                   err_set   = 1'b1;
        end else if (spck_rise) begin
          if (count != CNT_SAT) count_next = count + CNT_W'(1);
        end else if (spck_fall && (count != '0)) begin
          // A fall before the first rise is a glitch or pre-frame leftover.
          shreg_next  = {shreg[WIDTH-2:0], 1'b0};
          tx_bit_next = shreg[WIDTH-2];
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Control and output registers; the error set outranks a coincident clear.
  always_ff @(posedge ck_1356meg) begin
    if (!rst_n) begin
      state      <= IDLE;
      count      <= '0;
      tx_bit     <= 1'b0;
      tx_en      <= 1'b0;
      frame_done <= 1'b0;
      xfer_err   <= 1'b0;
    end else begin
      state      <= state_next;
      count      <= count_next;
      tx_bit     <= tx_bit_next;
      tx_en      <= tx_en_next;
      frame_done <= done_next;
      if (err_set)      xfer_err <= 1'b1;
      else if (err_clr) xfer_err <= 1'b0;
    end
  end

  // Word shift register; pure data, only observable while a frame is active.
  always_ff @(posedge ck_1356meg) begin
    shreg <= shreg_next;
  end

endmodule

// File: tb/tb_spi_status_responder.sv
// Bench for spi_status_responder: plays the ARM on two instances (WIDTH=16 and
// WIDTH=8), samples miso on each rising spck and compares against the word
// captured at frame start, plus frame_done / xfer_err outcomes by pulse count.
module tb_spi_status_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] status16;
  logic [7:0]  status8;
  logic        err_clr16, err_clr8;
  logic        done16, done8, err16, err8;

  int n_assert = 0;
  int n_fail   = 0;
  int done_cnt16 = 0;
  int done_cnt8  = 0;
  bit err_m [2];

  always #5 clk = ~clk;

  spi_status_responder_if bus16 ();
  spi_status_responder_if bus8 ();

  spi_status_responder #(.WIDTH(16), .SYNC_STAGES(2)) dut16 (
    .ck_1356meg (clk),
    .rst_n      (rst_n),
    .spi        (bus16.slave),
    .status     (status16),
    .err_clr    (err_clr16),
    .frame_done (done16),
    .xfer_err   (err16)
  );

  spi_status_responder #(.WIDTH(8), .SYNC_STAGES(2)) dut8 (
    .ck_1356meg (clk),
    .rst_n      (rst_n),
    .spi        (bus8.slave),
    .status     (status8),
    .err_clr    (err_clr8),
    .frame_done (done8),
    .xfer_err   (err8)
  );

  always @(posedge clk) begin
    if (done16 === 1'b1) done_cnt16 <= done_cnt16 + 1;
    if (done8 === 1'b1)  done_cnt8  <= done_cnt8 + 1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit sel, input logic s, input logic n);
    if (sel) begin bus8.spck = s; bus8.ncs = n; end
    else     begin bus16.spck = s; bus16.ncs = n; end
  endtask

  function automatic logic oe_of(input bit sel);
    return sel ? bus8.miso_oe : bus16.miso_oe;
  endfunction

  function automatic logic miso_of(input bit sel);
    return sel ? bus8.miso : bus16.miso;
  endfunction

  function automatic logic err_of(input bit sel);
    return sel ? err8 : err16;
  endfunction

  function automatic int done_of(input bit sel);
    return sel ? done_cnt8 : done_cnt16;
  endfunction

  task automatic checkb(input string tag, input logic obs, input logic want);
    n_assert++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %b, expected %b", tag, obs, want);
    end
  endtask

  task automatic checki(input string tag, input int obs, input int want);
    n_assert++;
    assert (obs == want) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, want);
    end
  endtask

  task automatic set_status(input bit sel, input logic [15:0] word);
    if (sel) status8 = word[7:0];
    else     status16 = word;
  endtask

  task automatic clear_err(input bit sel);
    if (sel) err_clr8 = 1'b1; else err_clr16 = 1'b1;
    tick;
    if (sel) err_clr8 = 1'b0; else err_clr16 = 1'b0;
    err_m[sel] = 1'b0;
    tick;
    checkb("err_clr", err_of(sel), 1'b0);
  endtask

  // One ARM frame. Model: bit i (1-based) read on the i-th rising spck is
  // word[W-i] while i <= W, else 0; a frame counted with exactly W rises gives
  // one frame_done, any other count sets the sticky error.
  task automatic frame(input bit sel, input int npulses, input logic [15:0] word,
                       input int half, input bit collide, input int snap_at,
                       input logic [15:0] snap_word, input int rst_at,
                       input bit clr_end);
    int   w, done0, rises;
    bit   active;
    logic want_bit;
    w      = sel ? 8 : 16;
    active = 1'b1;
    set_status(sel, word);
    done0 = done_of(sel);
    checkb("err_hold", err_of(sel), err_m[sel]);
    drive(sel, 1'b0, 1'b0);
    tick; tick;
    checkb("oe_start_pre", oe_of(sel), 1'b0);
    tick;
    checkb("oe_start", oe_of(sel), 1'b1);
    checkb("first_bit", miso_of(sel), word[w-1]);
    tick;
    for (int i = 1; i <= npulses; i++) begin
      want_bit = (i <= w) ? word[w-i] : 1'b0;
      if (!active) want_bit = 1'b0;
      checkb($sformatf("bit%0d", i), miso_of(sel), want_bit);
      checkb($sformatf("oe_bit%0d", i), oe_of(sel), active);
      if (collide && i == npulses) break;
      drive(sel, 1'b1, 1'b0);
      repeat (half) tick;
      drive(sel, 1'b0, 1'b0);
      repeat (half) tick;
      if (i == snap_at) set_status(sel, snap_word);
      if (i == rst_at) begin
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        active = 1'b0;
        err_m[0] = 1'b0;
        err_m[1] = 1'b0;
      end
    end
    if (collide) begin
      drive(sel, 1'b1, 1'b1);
      rises = npulses - 1;
    end else begin
      drive(sel, 1'b0, 1'b1);
      rises = npulses;
    end
    tick; tick;
    if (clr_end) begin
      if (sel) err_clr8 = 1'b1; else err_clr16 = 1'b1;
    end
    checkb("oe_end_pre", oe_of(sel), active);
    tick;
    err_clr8  = 1'b0;
    err_clr16 = 1'b0;
    checkb("oe_end", oe_of(sel), 1'b0);
    checkb("miso_end", miso_of(sel), 1'b0);
    if (clr_end) err_m[sel] = 1'b0;
    if (active && rises != w) err_m[sel] = 1'b1;
    checkb("xfer_err", err_of(sel), err_m[sel]);
    drive(sel, 1'b0, 1'b1);
    repeat (4) tick;
    checki("frame_done_cnt", done_of(sel) - done0, (active && rises == w) ? 1 : 0);
  endtask

  initial begin
    int          np, hf;
    logic [15:0] rw;
    bit          ce;
    rst_n     = 1'b0;
    status16  = '0;
    status8   = '0;
    err_clr16 = 1'b0;
    err_clr8  = 1'b0;
    err_m[0]  = 1'b0;
    err_m[1]  = 1'b0;
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    repeat (3) tick;
    checkb("rst_oe16", bus16.miso_oe, 1'b0);
    checkb("rst_miso16", bus16.miso, 1'b0);
    checkb("rst_done16", done16, 1'b0);
    checkb("rst_err16", err16, 1'b0);
    checkb("rst_oe8", bus8.miso_oe, 1'b0);
    checkb("rst_err8", err8, 1'b0);
    rst_n = 1'b1;
    repeat (10) tick;

    // Nominal frame
    frame(1'b0, 16, 16'hA5C3, 4, 1'b0, 0, 16'h0, 0, 1'b0);
    // Short frame, error held across a good frame, then cleared
    frame(1'b0, 15, 16'($urandom), 4, 1'b0, 0, 16'h0, 0, 1'b0);
    frame(1'b0, 16, 16'($urandom), 5, 1'b0, 0, 16'h0, 0, 1'b0);
    clear_err(1'b0);
    // Long frame: trailing bits read 0
    frame(1'b0, 18, 16'($urandom), 4, 1'b0, 0, 16'h0, 0, 1'b0);
    clear_err(1'b0);
    // Snapshot: status change mid-frame is ignored until the next frame
    frame(1'b0, 16, 16'hFFFF, 4, 1'b0, 4, 16'h0000, 0, 1'b0);
    frame(1'b0, 16, 16'h0000, 4, 1'b0, 0, 16'h0, 0, 1'b0);
    // Reset mid-frame, then a clean frame
    frame(1'b0, 16, 16'($urandom), 4, 1'b0, 0, 16'h0, 5, 1'b0);
    frame(1'b0, 16, 16'h1234, 4, 1'b0, 0, 16'h0, 0, 1'b0);
    // ncs rise merged with the 16th spck rise, err_clr coincident with the error
    frame(1'b0, 16, 16'($urandom), 4, 1'b1, 0, 16'h0, 0, 1'b1);
    clear_err(1'b0);
    // Randomized frames
    for (int k = 0; k < 8; k++) begin
      np = ($urandom_range(0, 2) == 0) ? int'($urandom_range(14, 18)) : 16;
      rw = 16'($urandom);
      hf = int'($urandom_range(4, 6));
      ce = 1'($urandom_range(0, 1));
      frame(1'b0, np, rw, hf, 1'b0, 0, 16'h0, 0, ce);
    end
    // Narrow instance
    frame(1'b1, 8, 16'h0081, 4, 1'b0, 0, 16'h0, 0, 1'b0);
    frame(1'b1, 7, 16'($urandom), 4, 1'b0, 0, 16'h0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
